med_filter: RTL and testbench
=============================

Name: med_filter

Overview:
Streaming median/glitch filter for sync-path timing samples. It sits directly downstream of the median config register bank and consumes its three register outputs (medregs_med_reg_data_out0..2) as live configuration. Samples arrive valid-qualified, one per cycle maximum. Each output is either the window median or the centre sample with outliers replaced by the median. An optional decimation stage thins the output stream.

Parameters:
MSB, 15, data/config MSB from the shared sync parameter include; sample width is MSB+1.

Ports:
clk  input  1  system clock
rst_n  input  1  reset
medregs_med_reg_data_out0  input  MSB+1  cfg: [0]=en, [1]=win5 (0: 3-tap, 1: 5-tap), [2]=mode (0: median, 1: outlier-replace); other bits ignored
medregs_med_reg_data_out1  input  MSB+1  cfg: [7:0]=decimation factor D
medregs_med_reg_data_out2  input  MSB+1  cfg: outlier threshold THR, unsigned
med_in_valid  input  1  sample strobe
med_in_data  input  MSB+1  unsigned sample
med_out_valid  output  1  one-cycle output strobe
med_out_data  output  MSB+1  filtered sample
med_out_outlier  output  1  |centre-median| > THR for this output
med_out_cnt  output  16  number of outputs emitted

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; history, fill count, decimation counter and pipeline cleared.
- History:
  - 5-entry shift register h0 (newest) to h4.
  - On med_in_valid & en: shift in med_in_data; fill increments, saturating at 5.
  - med_in_valid is ignored when en=0.
- Window:
  - W=3 uses h0..h2, centre h1. W=5 uses h0..h4, centre h2.
  - A sample is eligible when fill after its shift is >= W.
- Pipeline:
  - Fixed 2-cycle latency. An eligible sample accepted at edge t produces med_out_valid=1 during the cycle after edge t+2.
  - Back-to-back input every cycle is supported and gives back-to-back outputs.
  - Stage 1 registers the sorting-network partial results plus the centre sample.
  - Stage 2 registers median, diff, output data and flag.
- Arithmetic:
  - All values unsigned.
  - diff = |centre - median|, computed MSB+2 wide; the magnitude fits in MSB+1.
  - outlier = diff > THR (strict).
- Output select:
  - mode=0: out = median.
  - mode=1: out = outlier ? median : centre.
  - med_out_outlier is valid in both modes.
  - med_out_data and med_out_outlier hold their last value while med_out_valid=0.
- Decimation:
  - Deff = (D==0) ? 1 : D.
  - Counter dc counts eligible samples. An eligible sample is emitted only when dc==0; dc then advances 0..Deff-1 and wraps.
  - If D is reduced so that dc >= Deff, dc wraps to 0 on the next eligible sample.
  - Non-emitted eligible samples produce no med_out_valid.
- med_out_cnt: increments on each med_out_valid and wraps 0xFFFF -> 0. Cleared only by reset.
- en deassert (cycle it is sampled 0):
  - fill and dc are cleared.
  - History contents are don't-care.
  - Samples already in the pipeline still complete and emit.
- win5 change while en=1: fill and dc cleared the cycle after the change is registered. A sample arriving in the same cycle as the change counts as the first sample of the new window (fill=1).
- mode, THR and D are sampled when a sample enters stage 1. Changes never corrupt an in-flight sample.
- Simultaneous en deassert and med_in_valid: the sample is dropped.
- Reset mid-operation: in-flight samples are discarded and no further med_out_valid is produced until refilled.

Test Plan:
- W=3, mode=0, D=1; inputs 10,50,20,30 on consecutive cycles -> no output for the first two. Outputs are 20, then 30, each 2 cycles after the 3rd and 4th input respectively, med_out_cnt=2.
- W=5, mode=0; inputs 5,1,4,2,3 -> single output 3 after the 5th sample; a 6th sample 9 -> output 3 (window 1,4,2,3,9).
- W=3, mode=1, THR=10; inputs 100,200,105 -> out 105, outlier=1. Next input 106 -> out 105 (centre), outlier=0.
- W=3, D=3; 9 inputs 1..9 -> 7 eligible medians (2..8), outputs 2, 5, 8 only; change D to 1 mid-stream -> every eligible sample emitted.
- Extremes, W=3, mode=1, THR=0x7FFF; inputs 0xFFFF,0x0000,0xFFFF -> median 0xFFFF, centre 0, out 0xFFFF, outlier=1. Also: med_out_cnt preset near 0xFFFF via long run wraps to 0.
- Flush cases:
  - Toggle win5 after 2 samples -> next output needs 3 (or 5) fresh samples.
  - Drop en with 2 samples in the pipeline -> both still emit.
  - Assert rst_n=0 mid-stream -> all outputs 0 immediately, no stale output after release.

Source files
------------

// File: rtl/med_filter.sv
// Streaming 3/5-tap median / outlier-replace filter with optional decimation.
// Latency is fixed at 2 cycles from sample acceptance to med_out_valid.
module med_filter #(
    parameter int MSB = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [MSB:0] medregs_med_reg_data_out0,
    input  logic [MSB:0] medregs_med_reg_data_out1,
    input  logic [MSB:0] medregs_med_reg_data_out2,
    input  logic         med_in_valid,
    input  logic [MSB:0] med_in_data,
    output logic         med_out_valid,
    output logic [MSB:0] med_out_data,
    output logic         med_out_outlier,
    output logic [15:0]  med_out_cnt
);

    typedef logic [MSB:0] smp_t;
    localparam int SW = MSB + 1;

    function automatic smp_t fmin(input smp_t a, input smp_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic smp_t fmax(input smp_t a, input smp_t b);
        return (a < b) ? b : a;
    endfunction

    logic       cfg_en, cfg_win5, cfg_mode;
    logic [7:0] cfg_dec;
    smp_t       cfg_thr;
    logic       unused_cfg;

    assign cfg_en     = medregs_med_reg_data_out0[0];
    assign cfg_win5   = medregs_med_reg_data_out0[1];
    assign cfg_mode   = medregs_med_reg_data_out0[2];
    assign cfg_dec    = medregs_med_reg_data_out1[7:0];
    assign cfg_thr    = medregs_med_reg_data_out2;
    assign unused_cfg = ^{medregs_med_reg_data_out0[MSB:3], medregs_med_reg_data_out1[MSB:8]};

    // Stage 0: history, fill tracking and eligibility
    smp_t       h_q [5];
    logic [2:0] fill_q, fill_d;
    logic       win5_q;
    logic       p_q, p_win5_q;
    logic       accept, win_chg, eligible;
    logic [2:0] need;

    always_comb begin
        accept  = med_in_valid & cfg_en;
        win_chg = cfg_en & (cfg_win5 != win5_q);
        fill_d  = fill_q;
        if (!cfg_en) begin
            fill_d = 3'd0;
        end else if (win_chg) begin
            fill_d = {2'b00, accept};
        end else if (accept && (fill_q != 3'd5)) begin
            fill_d = fill_q + 3'd1;
        end
        need     = cfg_win5 ? 3'd5 : 3'd3;
        eligible = accept && (fill_d >= need);
    end

    // Stage 1: pair sorts reduce both window sizes to a 3-input median problem.
    // For 5 taps, the smaller of the pair minima and the larger of the pair maxima
    // can never be the median, so only three candidates survive.
    smp_t       lo01, hi01, lo23, hi23;
    smp_t       s1_lo_d, s1_hi_d, s1_e_d, s1_c_d;
    logic [7:0] deff, dc_q, dc_d;
    logic       emit;

    always_comb begin
        lo01 = fmin(h_q[0], h_q[1]);
        hi01 = fmax(h_q[0], h_q[1]);
        lo23 = fmin(h_q[2], h_q[3]);
        hi23 = fmax(h_q[2], h_q[3]);
        if (p_win5_q) begin
            s1_lo_d = fmax(lo01, lo23);
            s1_hi_d = fmin(hi01, hi23);
            s1_e_d  = h_q[4];
            s1_c_d  = h_q[2];
        end else begin
            s1_lo_d = lo01;
            s1_hi_d = hi01;
            s1_e_d  = h_q[2];
            s1_c_d  = h_q[1];
        end
        deff = (cfg_dec == 8'd0) ? 8'd1 : cfg_dec;
        emit = p_q && (dc_q == 8'd0);
        dc_d = dc_q;
        if (p_q) begin
            dc_d = (dc_q >= deff - 8'd1) ? 8'd0 : dc_q + 8'd1;
        end
        if (!cfg_en || win_chg) begin
            dc_d = 8'd0;
        end
    end

    logic s1_v_q, s1_mode_q;
    smp_t s1_lo_q, s1_hi_q, s1_e_q, s1_c_q, s1_thr_q;

    // Stage 2: final median, |centre - median| and output select
    smp_t    med, mag, out_sel;
    logic    outl;
    logic [SW:0] diff_s;

    always_comb begin
        med     = fmax(fmin(s1_lo_q, s1_hi_q), fmin(fmax(s1_lo_q, s1_hi_q), s1_e_q));
        diff_s  = {1'b0, s1_c_q} - {1'b0, med};
        mag     = diff_s[SW] ? (~diff_s[MSB:0] + smp_t'(1)) : diff_s[MSB:0];
        outl    = mag > s1_thr_q;
        out_sel = (!s1_mode_q || outl) ? med : s1_c_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) h_q[i] <= '0;
            fill_q          <= 3'd0;
            win5_q          <= 1'b0;
            dc_q            <= 8'd0;
            p_q             <= 1'b0;
            p_win5_q        <= 1'b0;
            s1_v_q          <= 1'b0;
            s1_mode_q       <= 1'b0;
            s1_lo_q         <= '0;
            s1_hi_q         <= '0;
            s1_e_q          <= '0;
            s1_c_q          <= '0;
            s1_thr_q        <= '0;
            med_out_valid   <= 1'b0;
            med_out_data    <= '0;
            med_out_outlier <= 1'b0;
            med_out_cnt     <= 16'd0;
        end else begin
            if (accept) begin
                h_q[0] <= med_in_data;
                for (int i = 1; i < 5; i++) h_q[i] <= h_q[i-1];
            end
            fill_q   <= fill_d;
            win5_q   <= cfg_win5;
            dc_q     <= dc_d;
            p_q      <= eligible;
            p_win5_q <= cfg_win5;

            s1_v_q <= emit;
            if (p_q) begin
                s1_lo_q   <= s1_lo_d;
                s1_hi_q   <= s1_hi_d;
                s1_e_q    <= s1_e_d;
                s1_c_q    <= s1_c_d;
                s1_mode_q <= cfg_mode;
                s1_thr_q  <= cfg_thr;
            end

            med_out_valid <= s1_v_q;
            if (s1_v_q) begin
                med_out_data    <= out_sel;
                med_out_outlier <= outl;
                med_out_cnt     <= med_out_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_med_filter.sv
// Directed bench for med_filter: window sizes, modes, decimation, flushes,
// reset mid-stream and output counter wrap.
module tb_med_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg0, cfg1, cfg2;
    logic        in_v;
    logic [15:0] in_d;
    logic        out_v;
    logic [15:0] out_d;
    logic        out_o;
    logic [15:0] out_cnt;

    med_filter #(.MSB(15)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .medregs_med_reg_data_out0 (cfg0),
        .medregs_med_reg_data_out1 (cfg1),
        .medregs_med_reg_data_out2 (cfg2),
        .med_in_valid              (in_v),
        .med_in_data               (in_d),
        .med_out_valid             (out_v),
        .med_out_data              (out_d),
        .med_out_outlier           (out_o),
        .med_out_cnt               (out_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [16:0] obs_q[$];
    int          obs_cyc_q[$];
    bit          mon_en = 1'b1;

    always @(negedge clk) begin
        if (mon_en && out_v) begin
            obs_q.push_back({out_o, out_d});
            obs_cyc_q.push_back(cyc);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, output int acc);
        in_v = 1'b1;
        in_d = d;
        @(posedge clk);
        #1;
        acc  = cyc;
        in_v = 1'b0;
    endtask

    task automatic set_cfg(input bit en, input bit w5, input bit md, input logic [7:0] d,
                           input logic [15:0] thr);
        cfg0 = {13'd0, md, w5, en};
        cfg1 = {8'd0, d};
        cfg2 = thr;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] d, input bit o, input int ecyc);
        logic [16:0] e;
        int          c;
        chk({tag, "_avail"}, obs_q.size() > 0, 1);
        if (obs_q.size() > 0) begin
            e = obs_q.pop_front();
            c = obs_cyc_q.pop_front();
            chk({tag, "_data"}, e[15:0], d);
            chk({tag, "_outl"}, e[16], o);
            if (ecyc >= 0) chk({tag, "_cyc"}, c, ecyc);
        end
    endtask

    initial begin
        int a, b;
        rst_n = 1'b0;
        in_v  = 1'b0;
        in_d  = 16'd0;
        set_cfg(0, 0, 0, 8'd1, 16'd0);
        tick(3);
        chk("rst_valid", out_v, 0);
        chk("rst_data", out_d, 0);
        chk("rst_outl", out_o, 0);
        chk("rst_cnt", out_cnt, 0);
        rst_n = 1'b1;

        // 3-tap median, latency 2
        set_cfg(1, 0, 0, 8'd1, 16'd0);
        tick(2);
        send(16'd10, a); send(16'd50, a); send(16'd20, a); send(16'd30, b);
        tick(4);
        chk("t1_nout", obs_q.size(), 2);
        expect_out("t1_o0", 16'd20, 1, a + 2);
        expect_out("t1_o1", 16'd30, 1, b + 2);
        chk("t1_cnt", out_cnt, 2);

        // 5-tap median
        set_cfg(1, 1, 0, 8'd1, 16'd0);
        tick(2);
        send(16'd5, a); send(16'd1, a); send(16'd4, a); send(16'd2, a); send(16'd3, a);
        send(16'd9, b);
        tick(4);
        chk("t2_nout", obs_q.size(), 2);
        expect_out("t2_o0", 16'd3, 1, a + 2);
        expect_out("t2_o1", 16'd3, 1, b + 2);
        chk("t2_cnt", out_cnt, 4);

        // Outlier replace, THR=10
        set_cfg(1, 0, 1, 8'd1, 16'd10);
        tick(2);
        send(16'd100, a); send(16'd200, a); send(16'd105, a); send(16'd106, b);
        tick(4);
        chk("t3_nout", obs_q.size(), 2);
        expect_out("t3_o0", 16'd105, 1, a + 2);
        expect_out("t3_o1", 16'd105, 0, b + 2);
        chk("t3_cnt", out_cnt, 6);

        // Decimation D=3, then D reduced to 1 while dc=1
        set_cfg(0, 0, 0, 8'd3, 16'd0);
        tick(1);
        set_cfg(1, 0, 0, 8'd3, 16'd0);
        tick(1);
        for (int i = 1; i <= 9; i++) send(16'(i), a);
        tick(4);
        chk("t4_nout", obs_q.size(), 3);
        expect_out("t4_o0", 16'd2, 0, -1);
        expect_out("t4_o1", 16'd5, 0, -1);
        expect_out("t4_o2", 16'd8, 0, -1);
        chk("t4_cnt", out_cnt, 9);
        set_cfg(1, 0, 0, 8'd1, 16'd0);
        tick(1);
        send(16'd10, a); send(16'd11, a); send(16'd12, b);
        tick(4);
        chk("t4b_nout", obs_q.size(), 2);
        expect_out("t4b_o0", 16'd10, 0, -1);
        expect_out("t4b_o1", 16'd11, 0, b + 2);
        chk("t4b_cnt", out_cnt, 11);

        // Extremes
        set_cfg(0, 0, 1, 8'd1, 16'h7FFF);
        tick(1);
        set_cfg(1, 0, 1, 8'd1, 16'h7FFF);
        tick(1);
        send(16'hFFFF, a); send(16'h0000, a); send(16'hFFFF, a);
        tick(4);
        chk("t5_nout", obs_q.size(), 1);
        expect_out("t5_o0", 16'hFFFF, 1, a + 2);
        chk("t5_cnt", out_cnt, 12);

        // win5 toggle after 2 samples flushes the window
        set_cfg(0, 0, 0, 8'd1, 16'h7FFF);
        tick(1);
        set_cfg(1, 0, 0, 8'd1, 16'h7FFF);
        tick(1);
        send(16'd1, a); send(16'd2, a);
        set_cfg(1, 1, 0, 8'd1, 16'h7FFF);
        tick(2);
        send(16'd7, a); send(16'd8, a); send(16'd9, a); send(16'd10, a);
        tick(4);
        chk("t6_none", obs_q.size(), 0);
        send(16'd11, a);
        tick(4);
        chk("t6_nout", obs_q.size(), 1);
        expect_out("t6_o0", 16'd9, 0, a + 2);
        chk("t6_cnt", out_cnt, 13);

        // en drop with two samples in flight; simultaneous sample is dropped
        set_cfg(1, 0, 0, 8'd1, 16'h7FFF);
        tick(2);
        send(16'd20, a); send(16'd21, a); send(16'd22, a); send(16'd23, b);
        set_cfg(0, 0, 0, 8'd1, 16'h7FFF);
        in_v = 1'b1;
        in_d = 16'd99;
        tick(1);
        in_v = 1'b0;
        tick(4);
        chk("t7_nout", obs_q.size(), 2);
        expect_out("t7_o0", 16'd21, 0, a + 2);
        expect_out("t7_o1", 16'd22, 0, b + 2);
        chk("t7_cnt", out_cnt, 15);

        // Reset mid-stream
        set_cfg(1, 0, 0, 8'd1, 16'h7FFF);
        tick(1);
        send(16'd1, a); send(16'd2, a); send(16'd3, a); send(16'd4, a);
        rst_n = 1'b0;
        #1;
        chk("t8_rst_valid", out_v, 0);
        chk("t8_rst_data", out_d, 0);
        chk("t8_rst_cnt", out_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("t8_stale", obs_q.size(), 0);
        chk("t8_cnt0", out_cnt, 0);
        send(16'd5, a); send(16'd6, a); send(16'd7, a);
        tick(4);
        chk("t8_nout", obs_q.size(), 1);
        expect_out("t8_o0", 16'd6, 0, a + 2);
        chk("t8_cnt", out_cnt, 1);

        // Output counter wrap
        mon_en = 1'b0;
        in_v   = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            in_d = 16'(i);
            @(posedge clk);
        end
        #1;
        in_v = 1'b0;
        tick(4);
        chk("t9_cnt_max", out_cnt, 16'hFFFF);
        send(16'd100, a);
        tick(4);
        chk("t9_cnt_wrap", out_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
